mul_ctrl: RTL and testbench

Sequencing controller for the M-extension multiply path of the RV32IM core. Accepts MUL/MULH/MULHSU/MULHU requests from the execute stage over a valid/ready handshake. Drives a shared, pipelined unsigned 32x32 multiplier with magnitude operands and counts its latency. Applies the sign fix-up, selects the low or high word, and holds the result until writeback accepts it.

---
 rtl/mul_ctrl_if.sv | 37 +++
 rtl/mul_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mul_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_ctrl_if
// Description : Bundle of the mul_ctrl request, multiplier and result signals.
//               Signal names are given from the controller's point of view.
//               slave  - the controller (mul_ctrl)
//               master - execute stage / writeback / multiplier side
// Signals     : valid_i, ready_o, op_i[1:0], a_i[31:0], b_i[31:0], flush_i
//               mul_a_o[31:0], mul_b_o[31:0], mul_res_i[63:0]
//               valid_o, ready_i, res_o[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_ctrl_if;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [63:0] mul_res_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] res_o;

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i, mul_res_i, ready_i,
        output ready_o, mul_a_o, mul_b_o, valid_o, res_o
    );

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i, mul_res_i, ready_i,
        input  ready_o, mul_a_o, mul_b_o, valid_o, res_o
    );
endinterface
`default_nettype wire

// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_ctrl
// Description : Sequencer for the RV32 M-extension multiply path. Accepts
//               MUL/MULH/MULHSU/MULHU over valid/ready, feeds magnitude
//               operands to a shared pipelined unsigned 32x32 multiplier,
//               waits out its latency, applies the sign fix-up, selects the
//               low or high word and holds the result until writeback takes it.
// Ports       : clk    - core clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - mul_ctrl_if.slave (request, multiplier, result)
// Parameters  : MUL_LAT - multiplier latency in cycles (1..8)
//               CNT_W   - latency counter width, 2**CNT_W > MUL_LAT
// Options     : MUL_CTRL_FUSE_EN - when defined, keeps the last operand tag
//               and signed product so a matching request (e.g. MULH then MUL)
//               completes straight from the stored product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mul_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_lat = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sa;
    logic              r_sb;
    logic [1:0]        r_op;
    logic              r_ready;
    logic              r_valid;
    logic [31:0]       r_res;
    logic [31:0]       r_mul_a;
    logic [31:0]       r_mul_b;

    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic [31:0]       w_mag_a;
    logic [31:0]       w_mag_b;
    logic [63:0]       w_prod;
    logic [31:0]       w_res_sel;
    logic              w_last;
    logic              w_hit;
    logic [31:0]       w_fuse_res;

    // A request coinciding with a flush is never taken.
    assign w_accept  = bus.valid_i && r_ready && !bus.flush_i;

    // MUL low word is identical for any signedness, so op 00 runs unsigned.
    assign w_sa      = ((bus.op_i == 2'b01) || (bus.op_i == 2'b10)) && bus.a_i[31];
    assign w_sb      = (bus.op_i == 2'b01) && bus.b_i[31];
    assign w_mag_a   = w_sa ? (32'd0 - bus.a_i) : bus.a_i;
    assign w_mag_b   = w_sb ? (32'd0 - bus.b_i) : bus.b_i;

    assign w_prod    = (r_sa ^ r_sb) ? (64'd0 - bus.mul_res_i) : bus.mul_res_i;
    assign w_res_sel = (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // The counter is loaded with MUL_LAT and runs down to zero; the product is
    // taken on the edge after it reaches zero, giving MUL_LAT+1 cycles from
    // accept to valid_o.
    assign w_last    = (r_state == S_BUSY) && (r_cnt == '0);

`ifdef MUL_CTRL_FUSE_EN
    logic [31:0] r_tag_a;
    logic [31:0] r_tag_b;
    logic [1:0]  r_tag_cls;
    logic        r_tag_vld;
    logic [63:0] r_p;
    logic [1:0]  w_cls;

    // Class codes reuse funct3: 01 SS, 10 SU, 11 UU. Op 00 is computed
    // unsigned, so its product is filed as UU.
    assign w_cls      = (bus.op_i == 2'b00) ? 2'b11 : bus.op_i;
    assign w_hit      = r_tag_vld && (bus.a_i == r_tag_a) && (bus.b_i == r_tag_b) &&
                        ((bus.op_i == 2'b00) || (bus.op_i == r_tag_cls));
    assign w_fuse_res = (bus.op_i == 2'b00) ? r_p[31:0] : r_p[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_a   <= '0;
            r_tag_b   <= '0;
            r_tag_cls <= '0;
            r_tag_vld <= 1'b0;
            r_p       <= '0;
        end else if (bus.flush_i) begin
            r_tag_vld <= 1'b0;
        end else begin
            // On a hit the existing tag is kept: an op 00 hit must not
            // re-label a signed product as unsigned.
            if (w_accept && !w_hit) begin
                r_tag_a   <= bus.a_i;
                r_tag_b   <= bus.b_i;
                r_tag_cls <= w_cls;
                r_tag_vld <= 1'b1;
            end
            if (w_last) begin
                r_p <= w_prod;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_fuse_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_op    <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (bus.flush_i) begin
            // Flush wins over everything, including a same-cycle handshake;
            // res_o keeps its last value.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_op    <= bus.op_i;
                        r_mul_a <= w_mag_a;
                        r_mul_b <= w_mag_b;
                        r_ready <= 1'b0;
                        if (w_hit) begin
                            r_res   <= w_fuse_res;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= c_lat;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_last) begin
                        r_res   <= w_res_sel;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                S_DONE: begin
                    // ready_o rises registered, so a new request is taken no
                    // earlier than the cycle after the handshake.
                    if (bus.ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.valid_o = r_valid;
    assign bus.res_o   = r_res;
    assign bus.mul_a_o = r_mul_a;
    assign bus.mul_b_o = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_ctrl
// Description : Directed self-checking bench for mul_ctrl with a behavioural
//               pipelined unsigned multiplier. Latency is counted in clock
//               edges after the accept edge (0 = valid_o already high in the
//               cycle right after the accept edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;
    localparam int MUL_LAT = 2;
    localparam int EXP_LAT = MUL_LAT + 1;
`ifdef MUL_CTRL_FUSE_EN
    localparam int EXP_FUSE_LAT = 0;
`else
    localparam int EXP_FUSE_LAT = EXP_LAT;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mul_ctrl_if bus();

    mul_ctrl #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural unsigned multiplier, MUL_LAT register stages.
    logic [63:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'd0, bus.mul_a_o} * {32'd0, bus.mul_b_o};
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mul_res_i = pipe[MUL_LAT-1];

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] res;
    } vec_t;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic accept_req(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, output logic ok);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        for (int i = 0; i < 20 && !bus.ready_o; i++) @(negedge clk);
        ok = bus.ready_o;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output logic [31:0] res,
                              output logic rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (!bus.valid_o && lat < 20) begin
            rdy_seen = rdy_seen | bus.ready_o;
            @(negedge clk);
            lat++;
        end
        if (!bus.valid_o) lat = -1;
        res = bus.res_o;
    endtask

    task automatic consume();
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
    endtask

    // ------------------------------ tests ---------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.res_o !== 32'd0) begin n_err++; $display("FAIL reset_res: got %h want 0", bus.res_o); end
        n_cmp++; if (bus.mul_a_o !== 32'd0) begin n_err++; $display("FAIL reset_mul_a: got %h want 0", bus.mul_a_o); end
        n_cmp++; if (bus.mul_b_o !== 32'd0) begin n_err++; $display("FAIL reset_mul_b: got %h want 0", bus.mul_b_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_ops();
        vec_t        v [6];
        logic        ok;
        int          lat;
        logic [31:0] res;
        logic        rdy;
        v[0] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        v[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000};
        v[2] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        v[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        v[4] = '{2'b01, 32'hFFFFFFFF, 32'h00000005, 32'h00000001, 32'h00000005, 32'hFFFFFFFF};
        v[5] = '{2'b10, 32'h00000005, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'h00000004};
        for (int i = 0; i < 6; i++) begin
            accept_req(v[i].op, v[i].a, v[i].b, ok);
            wait_valid(lat, res, rdy);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ops%0d_accept: ready_o got %b want 1", i, ok); end
            n_cmp++; if (lat != EXP_LAT) begin n_err++; $display("FAIL ops%0d_latency: got %0d want %0d", i, lat, EXP_LAT); end
            n_cmp++; if (res !== v[i].res) begin n_err++; $display("FAIL ops%0d_res: got %h want %h", i, res, v[i].res); end
            n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL ops%0d_busy_ready: got %b want 0", i, rdy); end
            n_cmp++; if (bus.mul_a_o !== v[i].ma) begin n_err++; $display("FAIL ops%0d_mul_a: got %h want %h", i, bus.mul_a_o, v[i].ma); end
            n_cmp++; if (bus.mul_b_o !== v[i].mb) begin n_err++; $display("FAIL ops%0d_mul_b: got %h want %h", i, bus.mul_b_o, v[i].mb); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic        ok;
        int          lat;
        logic [31:0] res;
        logic        rdy;
        accept_req(2'b00, 32'd9, 32'd9, ok);
        wait_valid(lat, res, rdy);
        n_cmp++; if (res !== 32'h51) begin n_err++; $display("FAIL bp_res: got %h want 00000051", res); end
        // New request waits on the bus while the result is held.
        bus.valid_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'd3; bus.b_i = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, bus.valid_o); end
            n_cmp++; if (bus.res_o !== 32'h51) begin n_err++; $display("FAIL bp_hold_res%0d: got %h want 00000051", i, bus.res_o); end
            n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready%0d: got %b want 0", i, bus.ready_o); end
        end
        consume();
        @(negedge clk);
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_after_hs_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL bp_after_hs_ready: got %b want 1", bus.ready_o); end
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        wait_valid(lat, res, rdy);
        n_cmp++; if (lat != EXP_LAT) begin n_err++; $display("FAIL bp_b2b_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (res !== 32'd12) begin n_err++; $display("FAIL bp_b2b_res: got %h want 0000000c", res); end
        consume();
    endtask

    task automatic test_flush();
        logic        ok;
        int          lat;
        logic [31:0] res;
        logic        rdy;
        logic        seen;
        // Flush in the second BUSY cycle.
        accept_req(2'b01, 32'd5, 32'd6, ok);
        @(negedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL flush_busy_ready: got %b want 1", bus.ready_o); end
        seen = bus.valid_o;
        for (int i = 0; i < 5; i++) begin @(negedge clk); seen = seen | bus.valid_o; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_busy_valid: got %b want 0", seen); end
        accept_req(2'b00, 32'd3, 32'd4, ok);
        wait_valid(lat, res, rdy);
        n_cmp++; if (lat != EXP_LAT) begin n_err++; $display("FAIL flush_next_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (res !== 32'd12) begin n_err++; $display("FAIL flush_next_res: got %h want 0000000c", res); end
        consume();
        // Request presented with flush is dropped.
        @(negedge clk);
        bus.valid_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'd2; bus.b_i = 32'd2; bus.flush_i = 1'b1;
        @(posedge clk);
        #1 begin bus.valid_i = 1'b0; bus.flush_i = 1'b0; end
        @(negedge clk);
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL flush_same_cycle_ready: got %b want 1", bus.ready_o); end
        // Flush together with the writeback handshake.
        accept_req(2'b00, 32'd2, 32'd3, ok);
        wait_valid(lat, res, rdy);
        bus.flush_i = 1'b1; bus.ready_i = 1'b1;
        @(posedge clk);
        #1 begin bus.flush_i = 1'b0; bus.ready_i = 1'b0; end
        @(negedge clk);
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL flush_done_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL flush_done_ready: got %b want 1", bus.ready_o); end
        n_cmp++; if (bus.res_o !== 32'd6) begin n_err++; $display("FAIL flush_done_res_kept: got %h want 00000006", bus.res_o); end
    endtask

    task automatic test_reset_mid();
        logic        ok;
        int          lat;
        logic [31:0] res;
        logic        rdy;
        logic        seen;
        accept_req(2'b11, 32'h00010000, 32'h00010000, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", bus.ready_o); end
        n_cmp++; if (bus.res_o !== 32'd0) begin n_err++; $display("FAIL rstmid_res: got %h want 0", bus.res_o); end
        n_cmp++; if (bus.mul_a_o !== 32'd0) begin n_err++; $display("FAIL rstmid_mul_a: got %h want 0", bus.mul_a_o); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); seen = seen | bus.valid_o; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_valid: got %b want 0", seen); end
        accept_req(2'b11, 32'h00010000, 32'h00010000, ok);
        wait_valid(lat, res, rdy);
        n_cmp++; if (lat != EXP_LAT) begin n_err++; $display("FAIL rstmid_next_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (res !== 32'd1) begin n_err++; $display("FAIL rstmid_next_res: got %h want 00000001", res); end
        consume();
    endtask

    task automatic test_fuse();
        vec_t        v [5];
        int          el [5];
        logic        ok;
        int          lat;
        logic [31:0] res;
        logic        rdy;
        // 0x12345678 * 0x9ABCDEF0 = 0x0B00EA4E_242D2080 unsigned;
        // signed (b negative): 0xF8CC93D6_242D2080.
        v[0] = '{2'b01, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 32'hF8CC93D6}; el[0] = EXP_LAT;
        v[1] = '{2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 32'h242D2080}; el[1] = EXP_FUSE_LAT;
        v[2] = '{2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 32'h0B00EA4E}; el[2] = EXP_LAT;
        v[3] = '{2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 32'h0B00EA4E}; el[3] = EXP_FUSE_LAT;
        v[4] = '{2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 32'h242D2080}; el[4] = EXP_FUSE_LAT;
        for (int i = 0; i < 5; i++) begin
            accept_req(v[i].op, v[i].a, v[i].b, ok);
            wait_valid(lat, res, rdy);
            n_cmp++; if (lat != el[i]) begin n_err++; $display("FAIL fuse%0d_latency: got %0d want %0d", i, lat, el[i]); end
            n_cmp++; if (res !== v[i].res) begin n_err++; $display("FAIL fuse%0d_res: got %h want %h", i, res, v[i].res); end
            consume();
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = 32'd0;
        bus.b_i     = 32'd0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        test_reset();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_fuse();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
